axi4_master_port: RTL and testbench

- AXI4 initiator that converts a simple single-outstanding request/response interface into AXI4 master channel traffic.
- Sits between the core's fetch/load-store arbiter and the io_master_* bus. It drives the memory/device slave in the simulation top or SoC.
- Handles single-beat writes and single-beat or INCR-burst reads, with one transaction outstanding at a time.

---
 rtl/axi4_master_port.sv | 355 +++++++++++++++++++++++++++++++++++
 tb/tb_axi4_master_port.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_master_port.sv
// ---------------------------------------------------------------------------
// axi4_master_port
//
// Purpose:
//   AXI4 initiator that turns a simple single-outstanding request/response
//   interface (from the core's fetch/load-store arbiter) into AXI4 master
//   channel traffic on the io_master_* bus. Handles single-beat writes and
//   single-beat or INCR-burst reads, one transaction in flight at a time.
//
// Configuration macro:
//   AXI_MST_BURST_EN  - when defined, arlen carries the clamped request length
//                       and multi-beat INCR reads are performed. When
//                       undefined, arlen is forced to 0, req_len is ignored
//                       and every read is exactly one beat.
//
// Parameters:
//   AXI_ID   - constant ID driven on awid/arid, compared against bid/rid
//   MAX_LEN  - largest arlen issued; larger req_len is clamped to this
//
// Ports:
//   clock, reset               - clock, asynchronous active-high reset
//   req_valid / req_ready      - request handshake
//   req_write                  - 1 = write, 0 = read
//   req_addr/wdata/wstrb/len   - request address, write data, strobes, beats-1
//   rsp_valid/last/err/rdata   - one-cycle response pulse per read beat or
//                                per write completion
//   io_master_aw*/w*/b*/ar*/r* - AXI4 master channels
// ---------------------------------------------------------------------------
module axi4_master_port #(
    parameter logic [3:0] AXI_ID  = 4'h0,
    parameter logic [7:0] MAX_LEN = 8'd7
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    input  logic [7:0]  req_len,

    output logic        rsp_valid,
    output logic        rsp_last,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,

    input  logic        io_master_awready,
    output logic        io_master_awvalid,
    output logic [31:0] io_master_awaddr,
    output logic [3:0]  io_master_awid,
    output logic [7:0]  io_master_awlen,
    output logic [2:0]  io_master_awsize,
    output logic [1:0]  io_master_awburst,

    input  logic        io_master_wready,
    output logic        io_master_wvalid,
    output logic [31:0] io_master_wdata,
    output logic [3:0]  io_master_wstrb,
    output logic        io_master_wlast,

    output logic        io_master_bready,
    input  logic        io_master_bvalid,
    input  logic [3:0]  io_master_bid,
    input  logic [1:0]  io_master_bresp,

    input  logic        io_master_arready,
    output logic        io_master_arvalid,
    output logic [31:0] io_master_araddr,
    output logic [3:0]  io_master_arid,
    output logic [7:0]  io_master_arlen,
    output logic [2:0]  io_master_arsize,
    output logic [1:0]  io_master_arburst,

    output logic        io_master_rready,
    input  logic        io_master_rvalid,
    input  logic [31:0] io_master_rdata,
    input  logic [1:0]  io_master_rresp,
    input  logic        io_master_rlast,
    input  logic [3:0]  io_master_rid
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } state_t;

    // Current (registered) state
    state_t      r_state;
    logic        r_req_ready;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [7:0]  r_len;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_aw_done;
    logic        r_w_done;
    logic        r_bready;
    logic        r_arvalid;
    logic        r_rready;
    logic [7:0]  r_beat_cnt;
    logic        r_rsp_valid;
    logic        r_rsp_last;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    // Next-state values from the combinational process
    state_t      w_state_n;
    logic        w_req_ready_n;
    logic [31:0] w_addr_n;
    logic [31:0] w_wdata_n;
    logic [3:0]  w_wstrb_n;
    logic [7:0]  w_len_n;
    logic        w_awvalid_n;
    logic        w_wvalid_n;
    logic        w_aw_done_n;
    logic        w_w_done_n;
    logic        w_bready_n;
    logic        w_arvalid_n;
    logic        w_rready_n;
    logic [7:0]  w_beat_cnt_n;
    logic        w_rsp_valid_n;
    logic        w_rsp_last_n;
    logic        w_rsp_err_n;
    logic [31:0] w_rsp_rdata_n;

    // Helper terms
    logic [7:0]  w_req_len_eff;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_ar_hs;
    logic        w_r_hs;
    logic        w_b_hs;
    logic        w_cnt_zero;
    logic        w_last_beat;
    logic        w_beat_err;
    logic        w_aw_done_now;
    logic        w_w_done_now;

`ifdef AXI_MST_BURST_EN
    assign w_req_len_eff = (req_len > MAX_LEN) ? MAX_LEN : req_len;
`else
    // Single-beat reads only: the requested length is deliberately discarded.
    logic w_unused_len;
    assign w_unused_len  = ^{req_len, MAX_LEN};
    assign w_req_len_eff = 8'd0;
`endif

    assign w_aw_hs    = r_awvalid & io_master_awready;
    assign w_w_hs     = r_wvalid & io_master_wready;
    assign w_ar_hs    = r_arvalid & io_master_arready;
    assign w_r_hs     = r_rready & io_master_rvalid;
    assign w_b_hs     = r_bready & io_master_bvalid;
    assign w_cnt_zero = (r_beat_cnt == 8'd0);

    // A burst ends either when our own count runs out or when the slave says
    // so; any disagreement between the two is flagged as an error on the beat.
    assign w_last_beat = w_cnt_zero | io_master_rlast;
    assign w_beat_err  = (io_master_rresp != 2'b00) |
                         (io_master_rid != AXI_ID) |
                         (io_master_rlast != w_cnt_zero);

    // Write channels complete independently; fold this cycle's handshake in.
    assign w_aw_done_now = r_aw_done | w_aw_hs;
    assign w_w_done_now  = r_w_done | w_w_hs;

    // Next-state / next-output logic. Every output is a register, so this
    // process only computes what each register should hold after the edge.
    always_comb begin
        w_state_n     = r_state;
        w_req_ready_n = r_req_ready;
        w_addr_n      = r_addr;
        w_wdata_n     = r_wdata;
        w_wstrb_n     = r_wstrb;
        w_len_n       = r_len;
        w_awvalid_n   = r_awvalid;
        w_wvalid_n    = r_wvalid;
        w_aw_done_n   = r_aw_done;
        w_w_done_n    = r_w_done;
        w_bready_n    = r_bready;
        w_arvalid_n   = r_arvalid;
        w_rready_n    = r_rready;
        w_beat_cnt_n  = r_beat_cnt;
        w_rsp_valid_n = 1'b0;
        w_rsp_last_n  = r_rsp_last;
        w_rsp_err_n   = r_rsp_err;
        w_rsp_rdata_n = r_rsp_rdata;

        case (r_state)
            IDLE: begin
                w_req_ready_n = 1'b1;
                if (req_valid && r_req_ready) begin
                    w_req_ready_n = 1'b0;
                    w_addr_n      = req_addr;
                    w_wdata_n     = req_wdata;
                    w_wstrb_n     = req_wstrb;
                    w_len_n       = w_req_len_eff;
                    if (req_write) begin
                        w_awvalid_n = 1'b1;
                        w_wvalid_n  = 1'b1;
                        w_aw_done_n = 1'b0;
                        w_w_done_n  = 1'b0;
                        w_state_n   = WR_REQ;
                    end else begin
                        w_arvalid_n = 1'b1;
                        w_state_n   = RD_ADDR;
                    end
                end
            end

            RD_ADDR: begin
                if (w_ar_hs) begin
                    w_arvalid_n  = 1'b0;
                    w_rready_n   = 1'b1;
                    w_beat_cnt_n = r_len;
                    w_state_n    = RD_DATA;
                end
            end

            RD_DATA: begin
                if (w_r_hs) begin
                    w_rsp_valid_n = 1'b1;
                    w_rsp_rdata_n = io_master_rdata;
                    w_rsp_last_n  = w_last_beat;
                    w_rsp_err_n   = w_beat_err;
                    if (!w_cnt_zero) begin
                        w_beat_cnt_n = r_beat_cnt - 8'd1;
                    end
                    if (w_last_beat) begin
                        w_rready_n    = 1'b0;
                        w_req_ready_n = 1'b1;
                        w_state_n     = IDLE;
                    end
                end
            end

            WR_REQ: begin
                if (w_aw_hs) begin
                    w_awvalid_n = 1'b0;
                end
                if (w_w_hs) begin
                    w_wvalid_n = 1'b0;
                end
                w_aw_done_n = w_aw_done_now;
                w_w_done_n  = w_w_done_now;
                if (w_aw_done_now && w_w_done_now) begin
                    w_bready_n = 1'b1;
                    w_state_n  = WR_RESP;
                end
            end

            WR_RESP: begin
                if (w_b_hs) begin
                    w_rsp_valid_n = 1'b1;
                    w_rsp_last_n  = 1'b1;
                    w_rsp_rdata_n = 32'd0;
                    w_rsp_err_n   = (io_master_bresp != 2'b00) |
                                    (io_master_bid != AXI_ID);
                    w_bready_n    = 1'b0;
                    w_req_ready_n = 1'b1;
                    w_state_n     = IDLE;
                end
            end

            default: begin
                w_state_n     = IDLE;
                w_req_ready_n = 1'b1;
                w_awvalid_n   = 1'b0;
                w_wvalid_n    = 1'b0;
                w_bready_n    = 1'b0;
                w_arvalid_n   = 1'b0;
                w_rready_n    = 1'b0;
            end
        endcase
    end

    // State register. Reset is asynchronous so that every valid/ready drops
    // immediately, abandoning whatever transaction was in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_wstrb     <= 4'd0;
            r_len       <= 8'd0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_beat_cnt  <= 8'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            r_state     <= w_state_n;
            r_req_ready <= w_req_ready_n;
            r_addr      <= w_addr_n;
            r_wdata     <= w_wdata_n;
            r_wstrb     <= w_wstrb_n;
            r_len       <= w_len_n;
            r_awvalid   <= w_awvalid_n;
            r_wvalid    <= w_wvalid_n;
            r_aw_done   <= w_aw_done_n;
            r_w_done    <= w_w_done_n;
            r_bready    <= w_bready_n;
            r_arvalid   <= w_arvalid_n;
            r_rready    <= w_rready_n;
            r_beat_cnt  <= w_beat_cnt_n;
            r_rsp_valid <= w_rsp_valid_n;
            r_rsp_last  <= w_rsp_last_n;
            r_rsp_err   <= w_rsp_err_n;
            r_rsp_rdata <= w_rsp_rdata_n;
        end
    end

    assign req_ready         = r_req_ready;
    assign rsp_valid         = r_rsp_valid;
    assign rsp_last          = r_rsp_last;
    assign rsp_err           = r_rsp_err;
    assign rsp_rdata         = r_rsp_rdata;

    assign io_master_awvalid = r_awvalid;
    assign io_master_awaddr  = r_addr;
    assign io_master_awid    = AXI_ID;
    assign io_master_awlen   = 8'd0;
    assign io_master_awsize  = 3'b010;
    assign io_master_awburst = 2'b01;

    assign io_master_wvalid  = r_wvalid;
    assign io_master_wdata   = r_wdata;
    assign io_master_wstrb   = r_wstrb;
    assign io_master_wlast   = 1'b1;

    assign io_master_bready  = r_bready;

    assign io_master_arvalid = r_arvalid;
    assign io_master_araddr  = r_addr;
    assign io_master_arid    = AXI_ID;
    assign io_master_arlen   = r_len;
    assign io_master_arsize  = 3'b010;
    assign io_master_arburst = 2'b01;

    assign io_master_rready  = r_rready;

endmodule

// File: tb/tb_axi4_master_port.sv
// ---------------------------------------------------------------------------
// tb_axi4_master_port
//
// Directed bench for axi4_master_port. The AXI slave side is played by hand
// from the main initial block, one clock at a time, and every expected value
// is a hand-computed constant. Build with AXI_MST_BURST_EN defined to cover
// multi-beat reads; without it the single-beat read behaviour is covered.
// ---------------------------------------------------------------------------
module tb_axi4_master_port;

    logic        clock = 1'b0;
    logic        reset;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [7:0]  req_len;

    logic        rsp_valid;
    logic        rsp_last;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    logic        awready, awvalid;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wready, wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bready, bvalid;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        arready, arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready, rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    int checkCount    = 0;
    int passCount     = 0;
    int rspPulses     = 0;
    int expectedPulses = 0;

    logic [31:0] burstBeats [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    axi4_master_port dut (
        .clock             (clock),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_wstrb         (req_wstrb),
        .req_len           (req_len),
        .rsp_valid         (rsp_valid),
        .rsp_last          (rsp_last),
        .rsp_err           (rsp_err),
        .rsp_rdata         (rsp_rdata),
        .io_master_awready (awready),
        .io_master_awvalid (awvalid),
        .io_master_awaddr  (awaddr),
        .io_master_awid    (awid),
        .io_master_awlen   (awlen),
        .io_master_awsize  (awsize),
        .io_master_awburst (awburst),
        .io_master_wready  (wready),
        .io_master_wvalid  (wvalid),
        .io_master_wdata   (wdata),
        .io_master_wstrb   (wstrb),
        .io_master_wlast   (wlast),
        .io_master_bready  (bready),
        .io_master_bvalid  (bvalid),
        .io_master_bid     (bid),
        .io_master_bresp   (bresp),
        .io_master_arready (arready),
        .io_master_arvalid (arvalid),
        .io_master_araddr  (araddr),
        .io_master_arid    (arid),
        .io_master_arlen   (arlen),
        .io_master_arsize  (arsize),
        .io_master_arburst (arburst),
        .io_master_rready  (rready),
        .io_master_rvalid  (rvalid),
        .io_master_rdata   (rdata),
        .io_master_rresp   (rresp),
        .io_master_rlast   (rlast),
        .io_master_rid     (rid)
    );

    // Free-running 100 MHz clock
    always #5 clock = ~clock;

    // Count every response pulse mid-cycle so we can confirm each
    // transaction produced exactly the number of pulses we expect.
    always @(negedge clock) begin
        if (rsp_valid === 1'b1) rspPulses++;
    end

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h",
                     tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one request for a single cycle; it is accepted on that edge
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb,
                                 input logic [7:0] len);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        req_wstrb = strb;
        req_len   = len;
        tick();
        req_valid = 1'b0;
    endtask

    // Slave side: one R beat held for exactly one cycle
    task automatic sendBeat(input logic [31:0] data, input logic last);
        rvalid = 1'b1;
        rdata  = data;
        rlast  = last;
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    // Slave side: accept the pending AR after one cycle
    task automatic acceptAr();
        arready = 1'b1;
        tick();
        arready = 1'b0;
    endtask

    // Main directed sequence
    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        req_len   = '0;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        bid       = 4'h0;
        bresp     = 2'b00;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rdata     = '0;
        rresp     = 2'b00;
        rlast     = 1'b0;
        rid       = 4'h0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // ---- reset state and constant outputs ----
        checkOutput("reset req_ready", req_ready, 1);
        checkOutput("reset arvalid", arvalid, 0);
        checkOutput("reset awvalid", awvalid, 0);
        checkOutput("reset wvalid", wvalid, 0);
        checkOutput("reset bready", bready, 0);
        checkOutput("reset rready", rready, 0);
        checkOutput("reset rsp_valid", rsp_valid, 0);
        checkOutput("reset rsp_rdata", rsp_rdata, 0);
        checkOutput("const awsize", awsize, 3'b010);
        checkOutput("const arsize", arsize, 3'b010);
        checkOutput("const awburst", awburst, 2'b01);
        checkOutput("const arburst", arburst, 2'b01);
        checkOutput("const awlen", awlen, 0);
        checkOutput("const wlast", wlast, 1);

        // ---- single read, arready two cycles late ----
        applyStimulus(1'b0, 32'h8000_0000, 32'h0, 4'h0, 8'd0);
        checkOutput("rd1 arvalid rise", arvalid, 1);
        checkOutput("rd1 req_ready drop", req_ready, 0);
        checkOutput("rd1 araddr", araddr, 32'h8000_0000);
        checkOutput("rd1 arlen", arlen, 0);
        checkOutput("rd1 arid", arid, 0);
        tick();
        tick();
        checkOutput("rd1 arvalid held", arvalid, 1);
        checkOutput("rd1 araddr held", araddr, 32'h8000_0000);
        acceptAr();
        checkOutput("rd1 arvalid drop", arvalid, 0);
        checkOutput("rd1 rready", rready, 1);
        sendBeat(32'hDEAD_BEEF, 1'b1);
        expectedPulses += 1;
        checkOutput("rd1 rsp_valid", rsp_valid, 1);
        checkOutput("rd1 rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        checkOutput("rd1 rsp_last", rsp_last, 1);
        checkOutput("rd1 rsp_err", rsp_err, 0);
        checkOutput("rd1 req_ready back", req_ready, 1);
        checkOutput("rd1 rready drop", rready, 0);
        tick();
        checkOutput("rd1 rsp_valid pulse", rsp_valid, 0);
        checkOutput("rd1 pulse count", rspPulses, expectedPulses);

`ifdef AXI_MST_BURST_EN
        // ---- 4-beat burst with gaps between beats ----
        applyStimulus(1'b0, 32'h8000_0010, 32'h0, 4'h0, 8'd3);
        checkOutput("burst arlen", arlen, 3);
        checkOutput("burst araddr", araddr, 32'h8000_0010);
        acceptAr();
        for (int i = 0; i < 4; i++) begin
            sendBeat(burstBeats[i], (i == 3));
            checkOutput("burst rsp_valid", rsp_valid, 1);
            checkOutput("burst rsp_rdata", rsp_rdata, burstBeats[i]);
            checkOutput("burst rsp_last", rsp_last, (i == 3) ? 1 : 0);
            checkOutput("burst rsp_err", rsp_err, 0);
            tick();
            checkOutput("burst gap rsp_valid", rsp_valid, 0);
        end
        expectedPulses += 4;
        checkOutput("burst pulse count", rspPulses, expectedPulses);
        checkOutput("burst req_ready", req_ready, 1);

        // ---- burst whose 4th beat lacks rlast ----
        applyStimulus(1'b0, 32'h8000_0020, 32'h0, 4'h0, 8'd3);
        acceptAr();
        for (int i = 0; i < 3; i++) begin
            sendBeat(burstBeats[i], 1'b0);
        end
        sendBeat(32'h44, 1'b0);
        expectedPulses += 4;
        checkOutput("norlast rsp_last", rsp_last, 1);
        checkOutput("norlast rsp_err", rsp_err, 1);
        checkOutput("norlast rready", rready, 0);
        tick();

        // ---- length above MAX_LEN is clamped to 7 ----
        applyStimulus(1'b0, 32'h8000_0100, 32'h0, 4'h0, 8'd20);
        checkOutput("clamp arlen", arlen, 7);
        acceptAr();
        for (int i = 0; i < 8; i++) begin
            sendBeat(32'h100 + i, (i == 7));
            checkOutput("clamp rsp_last", rsp_last, (i == 7) ? 1 : 0);
        end
        expectedPulses += 8;
        checkOutput("clamp rsp_err", rsp_err, 0);
        tick();
        checkOutput("clamp pulse count", rspPulses, expectedPulses);
`else
        // ---- single-beat build: req_len ignored ----
        applyStimulus(1'b0, 32'h8000_0020, 32'h0, 4'h0, 8'd3);
        checkOutput("nolen arlen", arlen, 0);
        acceptAr();
        sendBeat(32'h55, 1'b1);
        expectedPulses += 1;
        checkOutput("nolen rsp_rdata", rsp_rdata, 32'h55);
        checkOutput("nolen rsp_last", rsp_last, 1);
        checkOutput("nolen rsp_err", rsp_err, 0);
        checkOutput("nolen req_ready", req_ready, 1);
        tick();
        checkOutput("nolen pulse count", rspPulses, expectedPulses);

        // Single beat without rlast is an error but still ends the read
        applyStimulus(1'b0, 32'h8000_0030, 32'h0, 4'h0, 8'd0);
        acceptAr();
        sendBeat(32'h66, 1'b0);
        expectedPulses += 1;
        checkOutput("nolast rsp_last", rsp_last, 1);
        checkOutput("nolast rsp_err", rsp_err, 1);
        checkOutput("nolast rready", rready, 0);
        tick();
`endif

        // ---- write with channel skew: W first, AW three cycles later ----
        applyStimulus(1'b1, 32'hA000_03F8, 32'h41, 4'b0001, 8'd0);
        checkOutput("wr awvalid", awvalid, 1);
        checkOutput("wr wvalid", wvalid, 1);
        checkOutput("wr awaddr", awaddr, 32'hA000_03F8);
        checkOutput("wr wdata", wdata, 32'h41);
        checkOutput("wr wstrb", wstrb, 4'b0001);
        checkOutput("wr awid", awid, 0);
        tick();
        wready = 1'b1;
        tick();
        wready = 1'b0;
        checkOutput("wr wvalid drop", wvalid, 0);
        checkOutput("wr awvalid still", awvalid, 1);
        checkOutput("wr bready early", bready, 0);
        tick();
        tick();
        checkOutput("wr bready wait", bready, 0);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        checkOutput("wr awvalid drop", awvalid, 0);
        checkOutput("wr bready", bready, 1);
        bvalid = 1'b1;
        bresp  = 2'b00;
        tick();
        bvalid = 1'b0;
        expectedPulses += 1;
        checkOutput("wr rsp_valid", rsp_valid, 1);
        checkOutput("wr rsp_last", rsp_last, 1);
        checkOutput("wr rsp_err", rsp_err, 0);
        checkOutput("wr rsp_rdata", rsp_rdata, 0);
        checkOutput("wr bready drop", bready, 0);
        checkOutput("wr req_ready", req_ready, 1);
        tick();

        // ---- stray bvalid while idle is ignored ----
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        checkOutput("stray b rsp_valid", rsp_valid, 0);
        checkOutput("stray b req_ready", req_ready, 1);

        // ---- write error, both channels accepted together ----
        applyStimulus(1'b1, 32'h0000_0010, 32'hCAFE, 4'hF, 8'd0);
        awready = 1'b1;
        wready  = 1'b1;
        tick();
        awready = 1'b0;
        wready  = 1'b0;
        checkOutput("wrerr both done", {awvalid, wvalid, bready}, 3'b001);
        bvalid = 1'b1;
        bresp  = 2'b10;
        tick();
        bvalid = 1'b0;
        bresp  = 2'b00;
        expectedPulses += 1;
        checkOutput("wrerr rsp_valid", rsp_valid, 1);
        checkOutput("wrerr rsp_err", rsp_err, 1);

        // Next request accepted straight away; it becomes the reset victim
        applyStimulus(1'b0, 32'h8000_0040, 32'h0, 4'h0, 8'd3);
        checkOutput("back2back arvalid", arvalid, 1);
        checkOutput("back2back req_ready", req_ready, 0);
        acceptAr();
        checkOutput("rst rready before", rready, 1);
`ifdef AXI_MST_BURST_EN
        sendBeat(32'h11, 1'b0);
        expectedPulses += 1;
        checkOutput("rst beat1 last", rsp_last, 0);
`endif

        // ---- asynchronous reset in the middle of a beat ----
        rvalid = 1'b1;
        rdata  = 32'h22;
        #3;
        reset = 1'b1;
        #1;
        checkOutput("rst async rready", rready, 0);
        checkOutput("rst async arvalid", arvalid, 0);
        checkOutput("rst async awvalid", awvalid, 0);
        checkOutput("rst async wvalid", wvalid, 0);
        checkOutput("rst async bready", bready, 0);
        checkOutput("rst async rsp_valid", rsp_valid, 0);
        checkOutput("rst async req_ready", req_ready, 1);
        rvalid = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // ---- read with a foreign rid is flagged ----
        applyStimulus(1'b0, 32'h8000_0080, 32'h0, 4'h0, 8'd0);
        acceptAr();
        rid = 4'h3;
        sendBeat(32'hABCD, 1'b1);
        rid = 4'h0;
        expectedPulses += 1;
        checkOutput("badid rsp_err", rsp_err, 1);
        tick();

        // ---- a normal single read completes after the reset ----
        applyStimulus(1'b0, 32'h8000_0090, 32'h0, 4'h0, 8'd0);
        checkOutput("post-rst araddr", araddr, 32'h8000_0090);
        acceptAr();
        sendBeat(32'h1234_5678, 1'b1);
        expectedPulses += 1;
        checkOutput("post-rst rsp_rdata", rsp_rdata, 32'h1234_5678);
        checkOutput("post-rst rsp_last", rsp_last, 1);
        checkOutput("post-rst rsp_err", rsp_err, 0);
        tick();
        checkOutput("total pulse count", rspPulses, expectedPulses);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
